// File: rtl/cnot_bist_if.sv
// Handshake and operand bundle between the CNOT BIST sequencer and its environment.
// The slave side is the sequencer; the master side is the controller plus the CNOT bank.
interface cnot_bist_if #(
    parameter int WIDTH = 1,
    parameter int ERR_W = 8
);
    logic                 start;
    logic                 abort;
    logic [WIDTH-1:0]     x1_o;
    logic [WIDTH-1:0]     x2_o;
    logic [WIDTH-1:0]     y1_i;
    logic [WIDTH-1:0]     y2_i;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_W-1:0]     err_count;
    logic                 fail_seen;
    logic [2*WIDTH-1:0]   first_fail_vec;

    modport master (
        output start, abort, y1_i, y2_i,
        input  x1_o, x2_o, busy, done, pass, err_count, fail_seen, first_fail_vec
    );

    modport slave (
        input  start, abort, y1_i, y2_i,
        output x1_o, x2_o, busy, done, pass, err_count, fail_seen, first_fail_vec
    );
endinterface

// File: rtl/cnot_bist_sequencer.sv
// Built-in self-test sequencer: sweeps every {x1,x2} operand pair through a CNOT bank,
// holds each for HOLD_CYCLES, then checks y1==x1 and y2==x1^x2.
module cnot_bist_sequencer #(
    parameter int WIDTH       = 1,
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic          clk,
    input  logic          rst,
    cnot_bist_if.slave    bus
);
    localparam int VW  = 2 * WIDTH;
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_r;
    logic [VW-1:0]      vec_r;
    logic [HCW-1:0]     hold_r;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [ERR_W-1:0]   err_r;
    logic               fail_seen_r;
    logic [VW-1:0]      first_fail_r;

    logic               mismatch_s;
    logic [ERR_W-1:0]   err_next_s;
    logic               last_vec_s;

    // Compare gate outputs against the held vector and precompute the saturating count.
    always_comb begin
        mismatch_s = 1'b0;
        err_next_s = err_r;
        last_vec_s = 1'b0;
        mismatch_s = (bus.y1_i != vec_r[VW-1:WIDTH]) ||
                     (bus.y2_i != (vec_r[VW-1:WIDTH] ^ vec_r[WIDTH-1:0]));
        if (err_r == {ERR_W{1'b1}}) begin
            err_next_s = err_r;
        end else begin
            err_next_s = err_r + ERR_W'(1);
        end
        last_vec_s = (vec_r == {VW{1'b1}});
    end

    // Sweep FSM; abort takes priority over start, and a start in DONE re-arms a fresh sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            vec_r        <= {VW{1'b0}};
            hold_r       <= {HCW{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            err_r        <= {ERR_W{1'b0}};
            fail_seen_r  <= 1'b0;
            first_fail_r <= {VW{1'b0}};
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start && !bus.abort) begin
                        state_r      <= APPLY;
                        vec_r        <= {VW{1'b0}};
                        hold_r       <= {HCW{1'b0}};
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        pass_r       <= 1'b0;
                        err_r        <= {ERR_W{1'b0}};
                        fail_seen_r  <= 1'b0;
                        first_fail_r <= {VW{1'b0}};
                    end else begin
                        state_r <= state_r;
                    end
                end
                APPLY: begin
                    if (bus.abort) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        vec_r   <= {VW{1'b0}};
                        hold_r  <= {HCW{1'b0}};
                    end else if (hold_r == HOLD_LAST) begin
                        state_r <= CHECK;
                        hold_r  <= {HCW{1'b0}};
                    end else begin
                        hold_r  <= hold_r + HCW'(1);
                    end
                end
                CHECK: begin
                    if (bus.abort) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        vec_r   <= {VW{1'b0}};
                        hold_r  <= {HCW{1'b0}};
                    end else begin
                        if (mismatch_s) begin
                            err_r <= err_next_s;
                            if (!fail_seen_r) begin
                                fail_seen_r  <= 1'b1;
                                first_fail_r <= vec_r;
                            end else begin
                                first_fail_r <= first_fail_r;
                            end
                        end else begin
                            err_r <= err_r;
                        end
                        // The last vector stays on the operand bus while DONE is held.
                        if (last_vec_s) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= ((mismatch_s ? err_next_s : err_r) == {ERR_W{1'b0}});
                        end else begin
                            state_r <= APPLY;
                            vec_r   <= vec_r + VW'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    vec_r   <= {VW{1'b0}};
                    hold_r  <= {HCW{1'b0}};
                end
            endcase
        end
    end

    assign bus.x1_o           = vec_r[VW-1:WIDTH];
    assign bus.x2_o           = vec_r[WIDTH-1:0];
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.pass           = pass_r;
    assign bus.err_count      = err_r;
    assign bus.fail_seen      = fail_seen_r;
    assign bus.first_fail_vec = first_fail_r;
endmodule

// File: doc/cnot_bist_sequencer.md
Name: cnot_bist_sequencer

Overview:
- Synthesizable built-in self-test driver that sits directly upstream of a WIDTH-bit bank of CNOT gates. It feeds the control (x1) and target (x2) operands and consumes the gate outputs (y1, y2).
- Walks every one of the 2^(2*WIDTH) operand combinations in order and holds each one for a settle window.
- Checks y1 == x1 and y2 == x1 ^ x2, then reports pass/fail, an error count and the first failing vector.
- Used on-chip in place of the simulation-only stimulus bench, and ahead of reversible ALU stages built from CNOT.

Parameters:
WIDTH, 1, bit width of each CNOT operand (x1, x2, y1, y2)
HOLD_CYCLES, 4, cycles each vector is driven before it is checked (min 1)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse that begins a sweep
abort  input  1  single-cycle pulse that ends a sweep early
x1_o  output  WIDTH  control operand to the CNOT bank
x2_o  output  WIDTH  target operand to the CNOT bank
y1_i  input  WIDTH  CNOT control output (expected x1)
y2_i  input  WIDTH  CNOT target output (expected x1^x2)
busy  output  1  sweep in progress
done  output  1  sweep completed (level)
pass  output  1  done and zero errors
err_count  output  ERR_W  number of failing vectors, saturating
fail_seen  output  1  at least one failure recorded this sweep
first_fail_vec  output  2*WIDTH  {x1,x2} of the first failing vector

Behaviour:
- Reset (async, rst=1): state=IDLE; every output and internal register is 0. This includes x1_o, x2_o, busy, done, pass, err_count, fail_seen, first_fail_vec, the vector counter vec and the hold counter.
- Reset mid-sweep: the sweep is lost and no done is produced. The block waits in IDLE for a new start.
- Vector mapping: vec is 2*WIDTH bits. x1_o = vec[2W-1:W], x2_o = vec[W-1:0], both registered. Order starts at 0 and increments by 1; for WIDTH=1 the order is 00, 01, 10, 11.
- FSM states: IDLE, APPLY, CHECK, DONE.
  - IDLE: busy=0. On start, the next edge clears vec, err_count, fail_seen, first_fail_vec and done, sets busy=1 and enters APPLY.
  - APPLY: drives vec for HOLD_CYCLES cycles; the hold counter counts 0..HOLD_CYCLES-1. After the last count, go to CHECK.
  - CHECK (1 cycle): compare y1_i/y2_i against the held vec. On mismatch:
    - err_count increments, saturating at 2^ERR_W-1.
    - If fail_seen=0, load first_fail_vec=vec and set fail_seen=1.
    - If vec is all-ones, go to DONE. Otherwise vec increments and the next state is APPLY.
  - DONE: busy=0, done=1, pass=(err_count==0). Held until the next start, which behaves exactly as start in IDLE.
- Timing: each vector costs HOLD_CYCLES+1 cycles. done rises 2^(2W)*(HOLD_CYCLES+1) cycles after the edge that samples start.
- x1_o/x2_o keep the last vector in DONE and go to 0 in IDLE.
- start while busy: ignored.
- abort while busy: next state IDLE, busy=0, done stays 0. err_count, fail_seen and first_fail_vec keep their values.
- abort in IDLE or DONE: no effect.
- abort and start in the same cycle: abort wins.
- No operand combination is skipped, and vec never wraps past all-ones.

Test Plan:
- WIDTH=1, HOLD=4, correct CNOT model. Pulse start → busy=1; x1/x2 step 00, 01, 10, 11, each held 5 cycles. done=1 exactly 20 cycles after start is sampled; pass=1, err_count=0, fail_seen=0.
- WIDTH=1, faulty model with y2=x2 (target never flips). Full sweep → err_count=2, first_fail_vec=2'b10, fail_seen=1, pass=0, done=1.
- WIDTH=2, HOLD=1, correct model → 16 vectors, done 32 cycles after start, pass=1. The final x1_o=2'b11 and x2_o=2'b11 persist in DONE.
- WIDTH=2, ERR_W=2, model with y1 inverted → 16 failures. err_count saturates at 3, first_fail_vec=4'b0000.
- Abort in the 3rd vector → IDLE on the next edge, done=0, busy=0. start+abort in the same cycle from IDLE → stays IDLE. A start pulse while busy → no restart, same done cycle as the undisturbed run.
- Assert rst mid-APPLY (async, between edges) → all outputs 0 immediately. After release, a start runs the full sweep; a second start in DONE clears err_count and re-sweeps.
